// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: 8 lines x 4-byte blocks, tag/valid hit check,
// victim write-back and block refill. Optional hit/miss counters under `define DCACHE_STATS_EN.
module dcache_controller #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned TAG_W     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [7:0]  HIT_COUNT,
  output logic [7:0]  MISS_COUNT
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FETCH,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES];

  logic [TAG_W-1:0] r_tag_q;
  logic [2:0]       r_idx_q;
  logic             r_entry;
  logic [7:0]       r_last_rd;

  logic [TAG_W-1:0] w_tag;
  logic [2:0]       w_idx;
  logic [1:0]       w_off;
  logic             w_req;
  logic             w_hit;
  logic [31:0]      w_line;
  logic [7:0]       w_sel_byte;
  logic             w_rd_hit;
  logic             w_wr_hit;
  logic             w_miss;

  assign w_tag      = ADDRESS[7:5];
  assign w_idx      = ADDRESS[4:2];
  assign w_off      = ADDRESS[1:0];
  assign w_req      = READ | WRITE;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line     = r_data[w_idx];
  assign w_sel_byte = w_line[{w_off, 3'b000} +: 8];

  always_comb begin
    w_next        = r_state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = r_last_rd;
    w_rd_hit      = 1'b0;
    w_wr_hit      = 1'b0;
    w_miss        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (WRITE) begin
              w_wr_hit = 1'b1;
            end else begin
              w_rd_hit = 1'b1;
              READDATA = w_sel_byte;
            end
          end else begin
            w_miss   = 1'b1;
            // Stall is combinational, so it must be masked while reset is held
            BUSYWAIT = ~RESET;
            w_next   = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FETCH;
          end
        end
      end
      S_WB: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[r_idx_q], r_idx_q};
        MEM_WRITEDATA = r_data[r_idx_q];
        BUSYWAIT      = 1'b1;
        if (!r_entry && !MEM_BUSYWAIT) w_next = S_FETCH;
      end
      S_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {r_tag_q, r_idx_q};
        BUSYWAIT    = 1'b1;
        if (!r_entry && !MEM_BUSYWAIT) w_next = S_REFILL;
      end
      S_REFILL: begin
        BUSYWAIT = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_entry marks the first cycle in a state; memory busy is ignored on that edge
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_entry <= 1'b0;
      r_tag_q <= '0;
      r_idx_q <= '0;
    end else begin
      r_state <= w_next;
      r_entry <= (w_next != r_state);
      if (w_miss) begin
        r_tag_q <= w_tag;
        r_idx_q <= w_idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid   <= '0;
      r_dirty   <= '0;
      r_last_rd <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_rd_hit) r_last_rd <= w_sel_byte;
      if (w_wr_hit) begin
        r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
        r_dirty[w_idx]                      <= 1'b1;
      end
      if (r_state == S_REFILL) begin
        r_data[r_idx_q]  <= MEM_READDATA;
        r_tag[r_idx_q]   <= r_tag_q;
        r_valid[r_idx_q] <= 1'b1;
        r_dirty[r_idx_q] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [7:0] r_hit_cnt;
  logic [7:0] r_miss_cnt;
  logic       r_post_refill;

  // The hit that completes a refilled miss is not a fresh hit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
      r_post_refill <= 1'b0;
    end else begin
      r_post_refill <= (r_state == S_REFILL);
      if ((w_rd_hit || w_wr_hit) && !r_post_refill && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 8'd1;
      if (w_miss && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 8'd1;
    end
  end

  assign HIT_COUNT  = r_hit_cnt;
  assign MISS_COUNT = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenario then random loads/stores against an
// array-level cache/memory model, with a latency-programmable memory responder.
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
  logic [7:0]  HIT_COUNT;
  logic [7:0]  MISS_COUNT;
`endif

  dcache_controller #(.NUM_LINES(8), .TAG_W(3)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [5:0] a);
    if (a == 6'h05) return 32'hDDCC_BBAA;
    return (32'h9E37_79B9 * {26'b0, a}) + 32'h1234_5678;
  endfunction

  // Memory responder: acts on the rising edge of a strobe, then stays busy mem_lat cycles
  logic [31:0] mem [64];
  bit          wrn [64];
  int unsigned mem_lat = 0;
  int unsigned busy_cnt;
  logic        prev_rd, prev_wr;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return wrn[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_BUSYWAIT <= 1'b0;
      MEM_READDATA <= '0;
      prev_rd      <= 1'b0;
      prev_wr      <= 1'b0;
      busy_cnt     <= 0;
    end else begin
      prev_rd <= MEM_READ;
      prev_wr <= MEM_WRITE;
      if ((MEM_READ && !prev_rd) || (MEM_WRITE && !prev_wr)) begin
        if (MEM_WRITE) begin
          mem[MEM_ADDRESS] <= MEM_WRITEDATA;
          wrn[MEM_ADDRESS] <= 1'b1;
        end else begin
          MEM_READDATA <= mem_word(MEM_ADDRESS);
        end
        if (mem_lat != 0) begin
          MEM_BUSYWAIT <= 1'b1;
          busy_cnt     <= mem_lat;
        end
      end else if (MEM_BUSYWAIT) begin
        if (busy_cnt <= 1) MEM_BUSYWAIT <= 1'b0;
        else busy_cnt <= busy_cnt - 1;
      end
    end
  end

  // Reference model: cache contents and backing memory as plain arrays
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_line  [8];
  logic [31:0] m_mem   [64];
  logic [7:0]  m_last;
  int          m_hits;
  int          m_misses;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_line[i]  = '0;
    end
    m_last   = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] o);
    logic [31:0] s;
    s = w >> (8 * int'(o));
    return s[7:0];
  endfunction

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One CPU access starting just after a negedge; ends after a request-free sample
  task automatic access(input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [2:0]  idx, tag;
    logic [1:0]  off;
    bit          hit, victim, saw_wb, saw_rd, both;
    logic [5:0]  wb_addr, rd_addr, exp_wb_addr;
    logic [31:0] wb_data, exp_wb_data, sh;
    int unsigned cyc, exp_cyc;
    idx = addr[4:2];
    tag = addr[7:5];
    off = addr[1:0];
    READ      = wr ? ($urandom_range(0, 1) != 0) : 1'b1;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = wd;
    #1;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    chk("busy_on_request", {31'b0, BUSYWAIT}, {31'b0, !hit});
    if (hit) begin
      chk("hit_no_strobe", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
      m_hits = sat(m_hits);
    end else begin
      victim      = m_valid[idx] && m_dirty[idx];
      exp_wb_addr = {m_tag[idx], idx};
      exp_wb_data = m_line[idx];
      m_misses    = sat(m_misses);
      cyc = 0; saw_wb = 0; saw_rd = 0; both = 0;
      wb_addr = '0; wb_data = '0; rd_addr = '0;
      while (BUSYWAIT === 1'b1 && cyc < 200) begin
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        if (MEM_READ && MEM_WRITE) both = 1;
        if (MEM_WRITE && !saw_wb && !saw_rd) begin
          saw_wb  = 1;
          wb_addr = MEM_ADDRESS;
          wb_data = MEM_WRITEDATA;
        end
        if (MEM_READ && !saw_rd) begin
          saw_rd  = 1;
          rd_addr = MEM_ADDRESS;
        end
      end
      exp_cyc = victim ? 6 + 2 * mem_lat : 4 + mem_lat;
      chk("miss_latency", cyc, exp_cyc);
      chk("strobe_exclusive", {31'b0, both}, 32'd0);
      chk("writeback_seen", {31'b0, saw_wb}, {31'b0, victim});
      if (victim) begin
        chk("wb_address", {26'b0, wb_addr}, {26'b0, exp_wb_addr});
        chk("wb_data", wb_data, exp_wb_data);
        m_mem[exp_wb_addr] = exp_wb_data;
      end
      chk("fetch_seen", {31'b0, saw_rd}, 32'd1);
      chk("fetch_address", {26'b0, rd_addr}, {26'b0, tag, idx});
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_line[idx]  = m_mem[{tag, idx}];
    end
    if (wr) begin
      sh = 32'hFF << (8 * int'(off));
      m_line[idx]  = (m_line[idx] & ~sh) | ({24'b0, wd} << (8 * int'(off)));
      m_dirty[idx] = 1'b1;
    end else begin
      m_last = byte_of(m_line[idx], off);
      chk("read_data", {24'b0, READDATA}, {24'b0, m_last});
    end
    @(posedge CLK);
    @(negedge CLK);
    READ  = 1'b0;
    WRITE = 1'b0;
    #1;
    chk("idle_no_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("idle_hold", {24'b0, READDATA}, {24'b0, m_last});
  endtask

  initial begin
    READ = 0; WRITE = 0; ADDRESS = '0; WRITEDATA = '0; RESET = 1'b0;
    for (int i = 0; i < 64; i++) m_mem[i] = init_word(6'(i));
    model_reset();
    #2 RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("rst_strobes", {30'b0, MEM_READ, MEM_WRITE}, 32'd0);
    chk("rst_mem_addr", {26'b0, MEM_ADDRESS}, 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_readdata", {24'b0, READDATA}, 32'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_counts", {16'b0, HIT_COUNT, MISS_COUNT}, 32'd0);
`endif
    RESET = 1'b0;
    @(negedge CLK);

    mem_lat = 3;
    access(0, 8'h14, 8'h00);
    chk("tp_read_14", {24'b0, READDATA}, 32'hAA);
    access(0, 8'h17, 8'h00);
    chk("tp_read_17", {24'b0, READDATA}, 32'hDD);
    access(1, 8'h15, 8'h5A);
    access(0, 8'h15, 8'h00);
    chk("tp_read_15", {24'b0, READDATA}, 32'h5A);
    access(0, 8'h34, 8'h00);
`ifdef DCACHE_STATS_EN
    chk("tp_hit_count", {24'b0, HIT_COUNT}, 32'd3);
    chk("tp_miss_count", {24'b0, MISS_COUNT}, 32'd2);
`endif

    // Reset while the fetch is outstanding
    READ = 1'b1; ADDRESS = 8'h14;
    #1;
    chk("rst_mid_busy_pre", {31'b0, BUSYWAIT}, 32'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_fetch_active", {31'b0, MEM_READ}, 32'd1);
    RESET = 1'b1;
    #1;
    chk("rst_mid_mem_read", {31'b0, MEM_READ}, 32'd0);
    chk("rst_mid_busy", {31'b0, BUSYWAIT}, 32'd0);
    chk("rst_mid_mem_addr", {26'b0, MEM_ADDRESS}, 32'd0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    #1;
    access(0, 8'h14, 8'h00);
    chk("post_rst_read_14", {24'b0, READDATA}, 32'hAA);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      mem_lat = $urandom_range(0, 3);
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a[7:6] = 2'b00;
      access($urandom_range(0, 1) != 0, a, 8'($urandom));
    end

    for (int i = 0; i < 64; i++) chk("final_memory", mem_word(6'(i)), m_mem[i]);
`ifdef DCACHE_STATS_EN
    chk("final_hit_count", {24'b0, HIT_COUNT}, m_hits);
    chk("final_miss_count", {24'b0, MISS_COUNT}, m_misses);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
